// File: rtl/csa_slice_seq_ctrl.sv
// csa_slice_seq_ctrl: multi-cycle wide adder that reuses one external 4-bit
// carry-select slice. Operands arrive on a valid/ready handshake, are added one
// nibble per cycle LSB first with the carry held in a register, and the
// {cout,sum} result leaves on a second valid/ready handshake.
// Optional build macro CSA_EARLY_EXIT_EN: finish early once the remaining
// operand nibbles are zero and no carry is pending (results are unchanged).
module csa_slice_seq_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy,
   output logic [3:0]       slc_a,
   output logic [3:0]       slc_b,
   output logic             slc_cin,
   input  logic [3:0]       slc_sum,
   input  logic             slc_cout
);

   localparam int NSLICE = WIDTH / 4;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   generate
      if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
         $error("csa_slice_seq_ctrl: WIDTH must be a multiple of 4 and >= 8");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic               carry;
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_r;
   logic [WIDTH-1:0]   acc_r;   // partial sum built up during RUN
   logic [WIDTH-1:0]   sum_r;   // published result, only updated on RUN->DONE
   logic               cout_r;

   logic [IDX_W+1:0]   bit_pos;
   logic               last;
   logic               early_exit;
   logic [WIDTH-1:0]   acc_nxt;
   logic [WIDTH-1:0]   low_mask;

   assign bit_pos  = {idx, 2'b00};
   assign last     = (idx == IDX_W'(NSLICE - 1));
   assign low_mask = ~({WIDTH{1'b1}} << bit_pos);
   assign sum      = sum_r;
   assign cout     = cout_r;

`ifdef CSA_EARLY_EXIT_EN
   // Remaining operand bits all zero with no carry pending: nothing left to add
   always_comb begin
      early_exit = (state == S_RUN) && (idx != '0) && !carry &&
                   ((a_r >> bit_pos) == '0) && ((b_r >> bit_pos) == '0);
   end
`else
   assign early_exit = 1'b0;
`endif

   // Partial sum with the current slice result merged into its nibble
   always_comb begin
      acc_nxt              = acc_r;
      acc_nxt[bit_pos +: 4] = slc_sum;
   end

   // Slice is driven only while a nibble is actually being computed
   always_comb begin
      slc_a   = 4'd0;
      slc_b   = 4'd0;
      slc_cin = 1'b0;
      if (state == S_RUN && !early_exit) begin
         slc_a   = a_r[bit_pos +: 4];
         slc_b   = b_r[bit_pos +: 4];
         slc_cin = carry;
      end
   end

   // Sequencer FSM with registered handshake/status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         idx       <= '0;
         carry     <= 1'b0;
         a_r       <= '0;
         b_r       <= '0;
         acc_r     <= '0;
         sum_r     <= '0;
         cout_r    <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  a_r      <= a;
                  b_r      <= b;
                  carry    <= cin;
                  idx      <= '0;
                  state    <= S_RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            S_RUN: begin
               if (early_exit) begin
                  sum_r     <= acc_r & low_mask;
                  cout_r    <= 1'b0;
                  state     <= S_DONE;
                  out_valid <= 1'b1;
               end else begin
                  acc_r <= acc_nxt;
                  carry <= slc_cout;
                  idx   <= idx + 1'b1;
                  if (last) begin
                     sum_r     <= acc_nxt;
                     cout_r    <= slc_cout;
                     state     <= S_DONE;
                     out_valid <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (out_valid && out_ready) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csa_slice_seq_ctrl.sv
// Testbench for csa_slice_seq_ctrl (WIDTH=16) with a behavioural 4-bit slice.
module tb_csa_slice_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        cin = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] sum;
   logic        cout;
   logic        busy;
   logic [3:0]  slc_a;
   logic [3:0]  slc_b;
   logic        slc_cin;
   logic [3:0]  slc_sum;
   logic        slc_cout;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign {slc_cout, slc_sum} = {1'b0, slc_a} + {1'b0, slc_b} + {4'd0, slc_cin};

   csa_slice_seq_ctrl #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .busy(busy), .slc_a(slc_a), .slc_b(slc_b),
      .slc_cin(slc_cin), .slc_sum(slc_sum), .slc_cout(slc_cout)
   );

   function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                           input logic c);
      return {1'b0, x} + {1'b0, y} + {16'd0, c};
   endfunction

   // Present operands and return positioned 1 time unit after the accepting edge.
   task automatic accept_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                            output bit ok);
      int w;
      @(negedge clk);
      a = ta; b = tb_; cin = tc; in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      ok = in_ready;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Count edges after the accept until out_valid is seen (bounded).
   task automatic wait_out(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1 lat++;
      end while (!out_valid && lat < 20);
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      checks++; if ({cout, sum} !== 17'd0) begin errors++; $display("FAIL reset_result got=%h want=0", {cout, sum}); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if ({slc_a, slc_b, slc_cin} !== 9'd0) begin errors++; $display("FAIL reset_slice got=%h want=0", {slc_a, slc_b, slc_cin}); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_overflow();
      bit ok;
      int lat;
      out_ready = 1'b1;
      accept_op(16'hFFFF, 16'h0001, 1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL ovf_accept in_ready never high"); end
      checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL ovf_busy got busy=%b in_ready=%b want 1/0", busy, in_ready); end
      wait_out(lat);
      checks++; if (lat != 4) begin errors++; $display("FAIL ovf_latency got=%0d want=4", lat); end
      checks++; if ({cout, sum} !== 17'h10000) begin errors++; $display("FAIL ovf_result got=%h want=10000", {cout, sum}); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL ovf_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
   endtask

   task automatic test_cin_seq();
      bit ok;
      int lat;
      logic [15:0] ta, tb_;
      int m, want_cin;
      ta = 16'h1234; tb_ = 16'h4321;
      accept_op(ta, tb_, 1'b1, ok);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         m = (1 << (4 * i)) - 1;
         want_cin = ((int'(ta) & m) + (int'(tb_) & m) + 1) >> (4 * i);
         checks++;
         if (slc_cin !== want_cin[0] || slc_a !== ta[4*i +: 4] || slc_b !== tb_[4*i +: 4]) begin
            errors++;
            $display("FAIL cin_seq[%0d] got cin=%b a=%h b=%h want cin=%0d a=%h b=%h",
                     i, slc_cin, slc_a, slc_b, want_cin, ta[4*i +: 4], tb_[4*i +: 4]);
         end
      end
      wait_out(lat);
      checks++; if ({cout, sum} !== 17'h05556) begin errors++; $display("FAIL cin_result got=%h want=05556", {cout, sum}); end
      @(posedge clk); #1;
   endtask

   task automatic test_hold();
      bit ok;
      int lat;
      out_ready = 1'b0;
      accept_op(16'h8001, 16'h7FFF, 1'b1, ok);
      wait_out(lat);
      checks++; if ({cout, sum} !== 17'h10001) begin errors++; $display("FAIL hold_result got=%h want=10001", {cout, sum}); end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== 17'h10001) begin
            errors++;
            $display("FAIL hold_stable[%0d] got v=%b rdy=%b res=%h want 1/0/10001", i, out_valid, in_ready, {cout, sum});
         end
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_release got v=%b rdy=%b want 0/1", out_valid, in_ready); end
   endtask

   task automatic test_reset_mid_run();
      bit ok;
      bit seen;
      accept_op(16'hAAAA, 16'h5555, 1'b0, ok);
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got v=%b rdy=%b busy=%b want 0/1/0", out_valid, in_ready, busy); end
      checks++; if ({cout, sum} !== 17'd0) begin errors++; $display("FAIL midrst_result got=%h want=0", {cout, sum}); end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (8) begin @(negedge clk); if (out_valid) seen = 1'b1; end
      checks++; if (seen) begin errors++; $display("FAIL midrst_no_output got out_valid=1 want 0"); end
   endtask

   task automatic test_early_exit();
      bit ok;
      int lat;
      int want_lat0, want_lat1;
`ifdef CSA_EARLY_EXIT_EN
      want_lat0 = 2; want_lat1 = 3;
`else
      want_lat0 = 4; want_lat1 = 4;
`endif
      accept_op(16'h0003, 16'h0004, 1'b0, ok);
      wait_out(lat);
      checks++; if ({cout, sum} !== 17'h00007) begin errors++; $display("FAIL ee_small_result got=%h want=00007", {cout, sum}); end
      checks++; if (lat != want_lat0) begin errors++; $display("FAIL ee_small_latency got=%0d want=%0d", lat, want_lat0); end
      @(posedge clk); #1;
      accept_op(16'h000F, 16'h0001, 1'b0, ok);
      wait_out(lat);
      checks++; if ({cout, sum} !== 17'h00010) begin errors++; $display("FAIL ee_carry_result got=%h want=00010", {cout, sum}); end
      checks++; if (lat != want_lat1) begin errors++; $display("FAIL ee_carry_latency got=%0d want=%0d", lat, want_lat1); end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic [16:0] q[$];
      logic [16:0] expv;
      int got;
      int cyc;
      localparam int N = 2000;
      got = 0;
      cyc = 0;
      fork
         begin
            for (int i = 0; i < N; i++) begin
               int w;
               @(negedge clk);
               repeat ($urandom_range(0, 2)) @(negedge clk);
               a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
               in_valid = 1'b1;
               w = 0;
               while (!in_ready && w < 200) begin @(negedge clk); w++; end
               if (!in_ready) begin
                  checks++; errors++;
                  $display("FAIL rand_accept_timeout at op %0d", i);
                  in_valid = 1'b0;
                  break;
               end
               @(posedge clk);
               q.push_back(ref_add(a, b, cin));
               #1 in_valid = 1'b0;
            end
         end
         begin
            while (got < N && cyc < 60000) begin
               @(negedge clk);
               cyc++;
               out_ready = 1'($urandom);
               if (out_valid && out_ready) begin
                  checks++;
                  if (q.size() == 0) begin
                     errors++;
                     $display("FAIL rand_extra_result got=%h want none", {cout, sum});
                  end else begin
                     expv = q.pop_front();
                     if ({cout, sum} !== expv) begin
                        errors++;
                        $display("FAIL rand_result[%0d] got=%h want=%h", got, {cout, sum}, expv);
                     end
                  end
                  got++;
               end
            end
         end
      join
      @(negedge clk);
      out_ready = 1'b1;
      checks++; if (got != N || q.size() != 0) begin errors++; $display("FAIL rand_count got=%0d pending=%0d want=%0d/0", got, q.size(), N); end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_overflow();
      test_cin_seq();
      test_hold();
      test_reset_mid_run();
      test_early_exit();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
